// File: rtl/dlf_op_sequencer.sv
// DL-Float cluster op sequencer: one op in flight, start/done/capture.
// Optional WAIT watchdog enabled by defining DLF_SEQ_TIMEOUT_EN.
module dlf_op_sequencer #(
  parameter int            W         = 16,
  parameter int            TO_CYCLES = 64,
  parameter logic [W-1:0]  TO_VALUE  = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [W-1:0] op_c,
  output logic [7:0]   unit_start,
  input  logic [7:0]   unit_done,
  output logic [2:0]   mux_sel,
  input  logic [W-1:0] mux_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   out_op,
  output logic         busy,
  output logic         out_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  logic [2:0] state;
  logic [2:0] op_q;

`ifdef DLF_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  assign out_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TO_VALUE, (TO_CYCLES == 0)};
  assign out_err = 1'b0;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  // One-hot start pulse for the latched opcode, only in ISSUE
  always_comb begin
    unit_start = '0;
    if (state == ST_ISSUE) begin
      unit_start[op_q] = 1'b1;
    end
  end

  // Sequencer FSM with operand, select and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      mux_sel  <= '0;
      out_data <= '0;
      out_op   <= '0;
`ifdef DLF_SEQ_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            op_a    <= in_a;
            op_b    <= in_b;
            op_c    <= in_c;
            mux_sel <= in_op;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef DLF_SEQ_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        ST_WAIT: begin
          if (unit_done[op_q]) begin
            state <= ST_CAPTURE;
          end
`ifdef DLF_SEQ_TIMEOUT_EN
          else if (cnt == CW'(TO_CYCLES - 1)) begin
            out_data <= TO_VALUE;
            out_op   <= op_q;
            err_q    <= 1'b1;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_CAPTURE: begin
          out_data <= mux_data;
          out_op   <= op_q;
`ifdef DLF_SEQ_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
